// File: rtl/nios_system_descriptor_mem_arbiter_pkg.sv
// Shared constants and types for the descriptor-memory arbiter.
// The lock state type is only referenced when ARB_LOCK_EN is defined.
package nios_system_desc_arb_pkg;

    localparam int DESC_ADDR_W     = 11;
    localparam int DESC_DATA_W     = 32;
    localparam int DESC_BE_W       = 4;
    localparam int DESC_RD_LATENCY = 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/nios_system_descriptor_mem_arbiter_if.sv
// Bundles the requester-side Avalon-MM signals and the memory-port signals.
// req_lock exists only when ARB_LOCK_EN is defined.
interface nios_system_descriptor_mem_arbiter_if
    import nios_system_desc_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DESC_ADDR_W,
    parameter int DATA_W  = DESC_DATA_W,
    parameter int BE_W    = DESC_BE_W
);
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [NUM_REQ*BE_W-1:0]   req_byteenable;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [DATA_W-1:0]         req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;
`ifdef ARB_LOCK_EN
    logic [NUM_REQ-1:0]        req_lock;
`endif
    logic [ADDR_W-1:0]         mem_address;
    logic                      mem_chipselect;
    logic                      mem_write;
    logic [DATA_W-1:0]         mem_writedata;
    logic [BE_W-1:0]           mem_byteenable;
    logic                      mem_clken;
    logic [DATA_W-1:0]         mem_readdata;

`ifdef ARB_LOCK_EN
    modport slave (
        input  req_address, req_read, req_write, req_writedata, req_byteenable, req_lock,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken,
        input  mem_readdata
    );
    modport master (
        output req_address, req_read, req_write, req_writedata, req_byteenable, req_lock,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken,
        output mem_readdata
    );
`else
    modport slave (
        input  req_address, req_read, req_write, req_writedata, req_byteenable,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken,
        input  mem_readdata
    );
    modport master (
        output req_address, req_read, req_write, req_writedata, req_byteenable,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  mem_address, mem_chipselect, mem_write, mem_writedata, mem_byteenable, mem_clken,
        output mem_readdata
    );
`endif

endinterface

// File: rtl/nios_system_descriptor_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found scanning from ptr_i
// upward (modulo NUM_REQ) wins; returns one-hot grant and its encoded index.
module nios_system_desc_rr_pick
    import nios_system_desc_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);
    int unsigned      j;
    logic [PTR_W-1:0] j_idx;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        j_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j     = (32'(ptr_i) + k) % NUM_REQ;
            j_idx = PTR_W'(j);
            if (!valid_o && req_i[j_idx]) begin
                valid_o        = 1'b1;
                idx_o          = j_idx;
                grant_o[j_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nios_system_descriptor_mem_arbiter.sv
// Round-robin arbiter sharing one descriptor-memory port among NUM_REQ requesters.
// Define ARB_LOCK_EN to add req_lock and the UNLOCKED/LOCKED hold-the-grant FSM.
module nios_system_descriptor_mem_arbiter
    import nios_system_desc_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DESC_ADDR_W,
    parameter int DATA_W  = DESC_DATA_W,
    parameter int BE_W    = DESC_BE_W
) (
    input logic clk,
    input logic reset_n,
    nios_system_descriptor_mem_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   win_idx;
    logic               any_grant;
    logic               win_read;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               rd_pend_q, rd_pend_d;
    logic [PTR_W-1:0]   rd_owner_q, rd_owner_d;

    function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    assign req = bus.req_read | bus.req_write;

`ifdef ARB_LOCK_EN
    lock_state_t        lock_state_q, lock_state_d;
    logic [PTR_W-1:0]   lock_owner_q, lock_owner_d;
    logic [NUM_REQ-1:0] owner_mask;

    always_comb begin
        owner_mask               = '0;
        owner_mask[lock_owner_q] = 1'b1;
    end

    // While locked, only the owner is eligible; reset masks everyone.
    assign pick_req = !reset_n ? '0 :
                      (lock_state_q == LOCKED) ? (req & owner_mask) : req;
`else
    assign pick_req = reset_n ? req : '0;
`endif

    nios_system_desc_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i   (pick_req),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .valid_o (any_grant)
    );

    // Write wins over a simultaneous read; that read gets no response.
    assign win_read = any_grant & ~bus.req_write[win_idx] & bus.req_read[win_idx];

    assign bus.req_waitrequest = req & ~grant;
    assign bus.req_readdata    = bus.mem_readdata;
    assign bus.mem_address     = bus.req_address[win_idx*ADDR_W +: ADDR_W];
    assign bus.mem_writedata   = bus.req_writedata[win_idx*DATA_W +: DATA_W];
    assign bus.mem_byteenable  = bus.req_byteenable[win_idx*BE_W +: BE_W];
    assign bus.mem_chipselect  = any_grant;
    assign bus.mem_write       = any_grant & bus.req_write[win_idx];
    assign bus.mem_clken       = 1'b1;

    always_comb begin
        bus.req_readdatavalid = '0;
        if (rd_pend_q) bus.req_readdatavalid[rd_owner_q] = 1'b1;
    end

    assign rd_pend_d  = win_read;
    assign rd_owner_d = win_idx;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_LOCK_EN
        lock_state_d = lock_state_q;
        lock_owner_d = lock_owner_q;
        unique case (lock_state_q)
            UNLOCKED: begin
                if (any_grant) begin
                    if (bus.req_lock[win_idx]) begin
                        lock_state_d = LOCKED;
                        lock_owner_d = win_idx;
                    end else begin
                        rr_ptr_d = ptr_after(win_idx);
                    end
                end
            end
            LOCKED: begin
                // Any grant here is to the owner, so it completes before release.
                if (!bus.req_lock[lock_owner_q] && (any_grant || !req[lock_owner_q])) begin
                    lock_state_d = UNLOCKED;
                    rr_ptr_d     = ptr_after(lock_owner_q);
                end
            end
            default: lock_state_d = UNLOCKED;
        endcase
`else
        if (any_grant) rr_ptr_d = ptr_after(win_idx);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state_q <= UNLOCKED;
            lock_owner_q <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`endif

endmodule

// File: tb/tb_nios_system_descriptor_mem_arbiter.sv
// Randomized and directed bench for the descriptor-memory arbiter, checked
// against a transaction-level model (priority scan, shadow memory, lock rules).
module tb_nios_system_descriptor_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_system_descriptor_mem_arbiter_if #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .BE_W (BW)
    ) bus ();

    nios_system_descriptor_mem_arbiter #(
        .NUM_REQ (N), .ADDR_W (AW), .DATA_W (DW), .BE_W (BW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Memory stand-in: one-cycle registered read, byte-enabled write.
    logic [31:0] mem_arr [2048];
    bit          written [2048];

    function automatic logic [31:0] init_word(input int a);
        if (a == 5)     return 32'hDEAD_BEEF;
        if (a == 'h7FF) return 32'hFFFF_FFFF;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return written[a] ? mem_arr[a] : init_word(int'(a));
    endfunction

    always @(posedge clk) begin
        if (bus.mem_chipselect) begin
            if (bus.mem_write) begin
                mem_arr[bus.mem_address] <= merge(mem_word(bus.mem_address),
                                                  bus.mem_writedata, bus.mem_byteenable);
                written[bus.mem_address] <= 1'b1;
            end else begin
                bus.mem_readdata <= mem_word(bus.mem_address);
            end
        end
    end

    // Requester stimulus
    bit          rd [N];
    bit          wr [N];
    bit          lk [N];
    logic [10:0] ad [N];
    logic [31:0] wd [N];
    logic [3:0]  be [N];

    // Reference model state
    int          ptr;
    bit          locked;
    int          lowner;
    bit          pend;
    int          pend_owner;
    logic [31:0] pend_data;
    logic [31:0] shadow [2048];
    logic [31:0] last_rdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; lk[i] = 1'b0;
            ad[i] = '0;   wd[i] = '0;   be[i] = 4'hF;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_read[i]                 = rd[i];
            bus.req_write[i]                = wr[i];
            bus.req_address[i*AW +: AW]     = ad[i];
            bus.req_writedata[i*DW +: DW]   = wd[i];
            bus.req_byteenable[i*BW +: BW]  = be[i];
`ifdef ARB_LOCK_EN
            bus.req_lock[i]                 = lk[i];
`endif
        end
    endtask

    // One bus cycle: drive, check at the falling edge, advance the model.
    task automatic step();
        int             win;
        logic [N-1:0]   reqv;
        logic [N-1:0]   gv;
        logic [N-1:0]   exp_rv;
        drive();
        @(negedge clk);
        reqv = '0;
        for (int i = 0; i < N; i++) reqv[i] = rd[i] | wr[i];
        win = -1;
        if (reset_n) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr + k) % N;
                if (win < 0 && reqv[j] && (!locked || j == lowner)) win = j;
            end
        end
        gv = '0;
        if (win >= 0) gv[win] = 1'b1;
        exp_rv = '0;
        if (pend) exp_rv[pend_owner] = 1'b1;

        check_eq("waitrequest", 64'(bus.req_waitrequest), 64'(reqv & ~gv));
        check_eq("chipselect", 64'(bus.mem_chipselect), 64'(win >= 0));
        check_eq("readdatavalid", 64'(bus.req_readdatavalid), 64'(exp_rv));
        if (pend) begin
            check_eq("readdata", 64'(bus.req_readdata), 64'(pend_data));
            last_rdata = bus.req_readdata;
        end
        if (win >= 0) begin
            check_eq("mem_address", 64'(bus.mem_address), 64'(ad[win]));
            check_eq("mem_write", 64'(bus.mem_write), 64'(wr[win]));
        end

        pend = 1'b0;
        if (win >= 0) begin
            if (wr[win]) shadow[ad[win]] = merge(shadow[ad[win]], wd[win], be[win]);
            else begin
                pend       = 1'b1;
                pend_owner = win;
                pend_data  = shadow[ad[win]];
            end
        end
        if (!locked) begin
            if (win >= 0) begin
                if (lk[win]) begin locked = 1'b1; lowner = win; end
                else ptr = (win + 1) % N;
            end
        end else if (!lk[lowner] && (win == lowner || !reqv[lowner])) begin
            locked = 1'b0;
            ptr    = (lowner + 1) % N;
        end
        if (!reset_n) begin ptr = 0; locked = 1'b0; pend = 1'b0; end
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        reset_n = 1'b0;
        ptr = 0; locked = 1'b0; pend = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) shadow[a] = init_word(a);
        ptr = 0; locked = 1'b0; lowner = 0; pend = 1'b0; pend_owner = 0;
        pend_data = '0; last_rdata = '0;
        idle_all();
        rd[0] = 1'b1; rd[1] = 1'b1;
        assert_reset();
        step();
        step();
        reset_n = 1'b1;

        // Single read of a preloaded word
        idle_all();
        rd[0] = 1'b1; ad[0] = 11'h005;
        step();
        idle_all();
        last_rdata = '0;
        step();
        check_eq("preload_rd", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);

        // Continuous reads from both requesters
        for (int c = 0; c < 8; c++) begin
            rd[0] = 1'b1; ad[0] = 11'(c);
            rd[1] = 1'b1; ad[1] = 11'(c + 16);
            step();
        end
        idle_all();
        step();

        // Partial write then read-back on consecutive cycles
        wr[1] = 1'b1; ad[1] = 11'h7FF; wd[1] = 32'h1234_5678; be[1] = 4'b0011;
        step();
        idle_all();
        rd[1] = 1'b1; ad[1] = 11'h7FF;
        step();
        idle_all();
        last_rdata = '0;
        step();
        check_eq("be_raw_rd", 64'(last_rdata), 64'h0000_0000_FFFF_5678);

        // Read and write together: write wins, no response
        rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 11'h020; wd[0] = 32'hAABB_CCDD; be[0] = 4'hF;
        step();
        idle_all();
        step();
        rd[0] = 1'b1; ad[0] = 11'h020;
        step();
        idle_all();
        last_rdata = '0;
        step();
        check_eq("rw_both_rd", 64'(last_rdata), 64'h0000_0000_AABB_CCDD);

        // Reset in the cycle after a granted read
        rd[0] = 1'b1; ad[0] = 11'h003; rd[1] = 1'b1; ad[1] = 11'h004;
        step();
        step();
        assert_reset();
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        idle_all();
        step();

`ifdef ARB_LOCK_EN
        // Locked read-modify-write while requester 1 keeps asking
        rd[0] = 1'b1; ad[0] = 11'h010; lk[0] = 1'b1;
        step();
        rd[0] = 1'b0;
        rd[1] = 1'b1; ad[1] = 11'h003;
        step();
        step();
        wr[0] = 1'b1; wd[0] = 32'h8000_0001; lk[0] = 1'b0;
        step();
        wr[0] = 1'b0;
        step();
        idle_all();
        step();
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                int op;
                op    = int'($urandom_range(0, 9));
                rd[i] = (op >= 2 && op <= 5) || op == 9;
                wr[i] = (op >= 6);
                ad[i] = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 7));
                wd[i] = $urandom;
                be[i] = 4'($urandom_range(0, 15));
`ifdef ARB_LOCK_EN
                lk[i] = ($urandom_range(0, 3) == 0);
`else
                lk[i] = 1'b0;
`endif
            end
            step();
        end
        idle_all();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nios_system_descriptor_mem_arbiter.md
Name: nios_system_descriptor_mem_arbiter

Overview:
- Shares one port of the 2048x32 dual-port descriptor memory among NUM_REQ Avalon-MM requesters, e.g. SGDMA descriptor fetch, SGDMA status writeback, and a Nios bridge.
- Round-robin arbitration, one transaction per cycle, fixed one-cycle read latency.
- Optional lock gives a requester an atomic read-modify-write on a descriptor, e.g. for the OWNED_BY_HW bit.
- Sits between the requesters and the memory's second slave port; runs on that port's clock.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 11, word address width.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).

Ports:
- clk  in  1  port clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_address  in  NUM_REQ*ADDR_W  per-requester word address, packed, requester 0 in the LSBs.
- req_read  in  NUM_REQ  read request.
- req_write  in  NUM_REQ  write request.
- req_writedata  in  NUM_REQ*DATA_W  write data.
- req_byteenable  in  NUM_REQ*BE_W  byte enables.
- req_waitrequest  out  NUM_REQ  stall; combinational.
- req_readdata  out  DATA_W  read data, broadcast to all requesters.
- req_readdatavalid  out  NUM_REQ  one-hot read-data strobe.
- req_lock  in  NUM_REQ  hold the grant (only when ARB_LOCK_EN is defined).
- mem_address  out  ADDR_W  to memory.
- mem_chipselect  out  1  to memory.
- mem_write  out  1  to memory.
- mem_writedata  out  DATA_W  to memory.
- mem_byteenable  out  BE_W  to memory.
- mem_clken  out  1  tied to 1.
- mem_readdata  in  DATA_W  memory q; valid one cycle after the address is presented.

Behaviour:
- Request and grant:
  - req[i] = req_read[i] | req_write[i].
  - Exactly one grant or none per cycle.
  - req_waitrequest[i] = req[i] & ~grant[i]; the transaction is accepted in the cycle waitrequest is low.
- Round robin:
  - rr_ptr (log2 NUM_REQ bits) marks the highest-priority requester. The winner is the first requesting index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ. No grant leaves rr_ptr unchanged.
- Memory side:
  - Combinational mux from the winner.
  - mem_chipselect = any grant.
  - mem_write = req_write of the winner.
  - If a requester asserts read and write together, write wins and the read is dropped (protocol error, no response).
- Read return:
  - Registers rd_pend (1b) and rd_owner.
  - The cycle after a granted read: req_readdatavalid[rd_owner]=1 and req_readdata=mem_readdata.
  - Latency is exactly 1 cycle; back-to-back reads from any mix of requesters are sustained at 1 per cycle.
- Writes: no response; complete on acceptance.
- Read-after-write to the same address on consecutive cycles returns the new data (memory port is single-port-consistent).
- Reset:
  - Asynchronous: rr_ptr=0, rd_pend=0, lock state=UNLOCKED, req_readdatavalid=0.
  - While reset_n=0: all grants forced 0, so mem_chipselect=0 and req_waitrequest=req.
  - A read accepted in the cycle before reset asserts gets no readdatavalid.
- The other memory port is not arbitrated here. Cross-port collisions are the software's responsibility (memory is DONT_CARE on mixed-port read-during-write).

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: two-state FSM, UNLOCKED and LOCKED(owner).
  - UNLOCKED -> LOCKED(i) on a grant to i with req_lock[i]=1. rr_ptr does not advance while locked.
  - In LOCKED, only the owner can be granted; others stall.
  - LOCKED -> UNLOCKED on an owner grant with req_lock=0 (that transaction completes first), or in any cycle where the owner has req_lock=0 and no request.
  - On unlock, rr_ptr <= owner+1.
- Undefined: req_lock port is absent, there is no FSM, and arbitration is pure round robin.

Decomposition:
- Package nios_system_desc_arb_pkg:
  - Constants DESC_ADDR_W=11, DESC_DATA_W=32, DESC_BE_W=4, DESC_RD_LATENCY=1.
  - lock_state_t enum {UNLOCKED, LOCKED}.
- Sub-module nios_system_desc_rr_pick: combinational round-robin picker. Inputs req vector and rr_ptr; outputs one-hot grant and encoded index.

Test Plan:
- Single requester 0 reads addr 0x005, memory preloaded with 0xDEADBEEF: waitrequest low in cycle 0; cycle 1 readdatavalid=01 and readdata=0xDEADBEEF.
- Both requesters issue continuous reads from rr_ptr=0: grants alternate 0,1,0,1; every cycle has exactly one readdatavalid, routed to the correct owner with the correct data.
- Requester 1 writes 0x12345678 with byteenable 0011 to addr 0x7FF over 0xFFFFFFFF, then reads it: returns 0xFFFF5678.
- Reset asserted mid-stream, the cycle after a granted read: readdatavalid stays 0, rr_ptr=0, mem_chipselect=0 until reset_n returns high.
- ARB_LOCK_EN: requester 0 reads addr 0x010 with lock=1 while requester 1 requests continuously. Requester 1 stalls until requester 0's write with lock=0 is granted; requester 1 is granted the next cycle.
- Requester asserts read and write together: write performed, no readdatavalid generated.
